data_peak_accumulate: RTL and testbench

DATA_PEAK_ACCUMULATE -- requirements
Module: data_peak_accumulate

---
 rtl/data_peak_accumulate_if.sv | 20 ++
 rtl/data_peak_accumulate.sv | 112 +++++++++++
 tb/tb_data_peak_accumulate.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/data_peak_accumulate_if.sv
// rtl/data_peak_accumulate_if.sv - sample/trigger/result bundle for data_peak_accumulate
// The sample source drives DataIn and the handshakes; the block returns result bytes.
interface data_peak_accumulate_if;
   logic [31:0] DataIn;
   logic        FastTrigger;
   logic        TxEnable;
   logic        DataReady;
   logic        DataValid;
   logic [7:0]  DataOut;

   modport master (
      output DataIn, FastTrigger, TxEnable,
      input  DataReady, DataValid, DataOut
   );

   modport slave (
      input  DataIn, FastTrigger, TxEnable,
      output DataReady, DataValid, DataOut
   );
endinterface

// File: rtl/data_peak_accumulate.sv
// rtl/data_peak_accumulate.sv - 128-sample peak/index/sum capture with 4-byte result readout
// Captures 32 words of four byte lanes, then emits Peak, PeakIdx, Sum[15:8], Sum[7:0].
module data_peak_accumulate (
   input  logic                         DataClk,
   input  logic                         Reset,
   input  logic                         SysClk,
   data_peak_accumulate_if.slave        bus
);
   typedef enum logic [1:0] {IDLE, CAPTURE, SEND} state_t;

   state_t      state;
   state_t      state_nx;
   logic [4:0]  cyc_cnt;
   logic [1:0]  byte_ptr;
   logic [7:0]  peak;
   logic [6:0]  peak_idx;
   logic [15:0] sum;

   logic [7:0]  cand_peak;
   logic [6:0]  cand_idx;
   logic [15:0] cand_sum;
   logic [7:0]  send_byte;
   logic        capture_en;
   logic        emit;

   // SysClk is a reserved pin with no function.
   logic        sys_clk_unused;
   assign sys_clk_unused = SysClk;

   // Lanes are folded oldest-first so a strict compare keeps the lowest index on ties;
   // the first word of a capture seeds the running values instead of the stale ones.
   always_comb begin
      logic [7:0] lane_v;
      cand_peak = peak;
      cand_idx  = peak_idx;
      cand_sum  = (cyc_cnt == 5'd0) ? 16'd0 : sum;
      lane_v    = 8'd0;
      for (int l = 0; l < 4; l++) begin
         lane_v   = bus.DataIn[8*l +: 8];
         cand_sum = cand_sum + 16'(lane_v);
         if ((cyc_cnt == 5'd0 && l == 0) || lane_v > cand_peak) begin
            cand_peak = lane_v;
            cand_idx  = {cyc_cnt, 2'(l)};
         end
      end
   end

   always_comb begin
      case (byte_ptr)
         2'd0:    send_byte = peak;
         2'd1:    send_byte = {1'b0, peak_idx};
         2'd2:    send_byte = sum[15:8];
         default: send_byte = sum[7:0];
      endcase
   end

   always_ff @(posedge DataClk) begin
      if (Reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      capture_en = 1'b0;
      emit       = 1'b0;
      case (state)
         IDLE: begin
            if (bus.FastTrigger) state_nx = CAPTURE;
         end
         CAPTURE: begin
            capture_en = 1'b1;
            if (cyc_cnt == 5'd31) state_nx = SEND;
         end
         SEND: begin
            emit = bus.TxEnable;
            if (bus.TxEnable && byte_ptr == 2'd3) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge DataClk) begin
      if (Reset) begin
         cyc_cnt       <= 5'd0;
         byte_ptr      <= 2'd0;
         peak          <= 8'd0;
         peak_idx      <= 7'd0;
         sum           <= 16'd0;
         bus.DataReady <= 1'b0;
         bus.DataValid <= 1'b0;
         bus.DataOut   <= 8'h00;
      end else begin
         bus.DataValid <= emit;
         if (state == IDLE) begin
            cyc_cnt  <= 5'd0;
            byte_ptr <= 2'd0;
         end
         if (capture_en) begin
            peak     <= cand_peak;
            peak_idx <= cand_idx;
            sum      <= cand_sum;
            cyc_cnt  <= cyc_cnt + 5'd1;
            if (cyc_cnt == 5'd31) bus.DataReady <= 1'b1;
         end
         if (emit) begin
            bus.DataOut <= send_byte;
            byte_ptr    <= byte_ptr + 2'd1;
            if (byte_ptr == 2'd3) bus.DataReady <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_data_peak_accumulate.sv
// tb/tb_data_peak_accumulate.sv - randomized bench for data_peak_accumulate
// Results are predicted from the 128 driven samples with plain loops over a flat sample list.
module tb_data_peak_accumulate;
   logic DataClk = 1'b0;
   logic SysClk  = 1'b0;
   logic Reset;

   always #5 DataClk = ~DataClk;
   always #7 SysClk  = ~SysClk;

   data_peak_accumulate_if bus ();

   data_peak_accumulate dut (
      .DataClk (DataClk),
      .Reset   (Reset),
      .SysClk  (SysClk),
      .bus     (bus)
   );

   int total = 0;
   int bad   = 0;
   logic [31:0] words [32];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic make_words(input int pat);
      for (int c = 0; c < 32; c++) begin
         case (pat)
            0: words[c] = 32'h01010101;
            1: words[c] = (c == 5) ? 32'h00FF0000 : 32'h0;
            2: words[c] = 32'hFFFFFFFF;
            3: words[c] = $urandom;
            default: begin
               for (int l = 0; l < 4; l++) words[c][8*l +: 8] = 8'($urandom_range(250, 255));
            end
         endcase
      end
   endtask

   // tx_mode: 0 held high, 1 DataReady delayed one register, 2 random, 3 alternating
   task automatic run_capture(input int pat, input int tx_mode, input bit noisy);
      logic [7:0] samples [128];
      logic [7:0] exp_b [4];
      int pk, pi, sm, k;
      bit early;
      logic tx_prev, rdy_last;
      logic [7:0] last_out;

      make_words(pat);
      for (int i = 0; i < 128; i++) samples[i] = words[i / 4][8 * (i % 4) +: 8];
      pk = 0; pi = 0; sm = 0;
      for (int i = 0; i < 128; i++) begin
         if (int'(samples[i]) > pk) begin pk = int'(samples[i]); pi = i; end
         sm += int'(samples[i]);
      end
      exp_b[0] = 8'(pk);
      exp_b[1] = 8'(pi);
      exp_b[2] = 8'(sm / 256);
      exp_b[3] = 8'(sm % 256);

      @(negedge DataClk);
      bus.FastTrigger = 1'b1;
      bus.TxEnable    = noisy ? 1'($urandom) : 1'b0;
      early = 1'b0;
      for (int c = 0; c < 32; c++) begin
         @(negedge DataClk);
         if (bus.DataReady !== 1'b0 || bus.DataValid !== 1'b0) early = 1'b1;
         bus.DataIn      = words[c];
         bus.FastTrigger = noisy ? 1'($urandom) : 1'b0;
         bus.TxEnable    = noisy ? 1'($urandom) : 1'b0;
      end
      check("ready_early", 32'(early), 32'd0);
      @(negedge DataClk);
      check("ready_latency", 32'(bus.DataReady), 32'd1);
      check("valid_at_ready", 32'(bus.DataValid), 32'd0);

      k = 0;
      last_out = bus.DataOut;
      rdy_last = 1'b0;
      for (int n = 0; n < 100 && k < 4; n++) begin
         case (tx_mode)
            0:       tx_prev = 1'b1;
            1:       tx_prev = rdy_last;
            2:       tx_prev = 1'($urandom);
            default: tx_prev = (n % 2 == 0);
         endcase
         rdy_last        = bus.DataReady;
         bus.TxEnable    = tx_prev;
         bus.FastTrigger = noisy ? 1'($urandom) : 1'b0;
         bus.DataIn      = $urandom;
         @(negedge DataClk);
         check("valid_vs_tx", 32'(bus.DataValid), 32'(tx_prev));
         if (bus.DataValid === 1'b1) begin
            check($sformatf("byte%0d", k), 32'(bus.DataOut), 32'(exp_b[k]));
            last_out = bus.DataOut;
            k++;
         end else begin
            check("out_hold", 32'(bus.DataOut), 32'(last_out));
         end
         check("ready_in_send", 32'(bus.DataReady), (k == 4) ? 32'd0 : 32'd1);
      end
      check("send_done", 32'(k), 32'd4);

      bus.FastTrigger = 1'b0;
      bus.TxEnable    = 1'b1;
      for (int n = 0; n < 3; n++) begin
         @(negedge DataClk);
         check("idle_valid", 32'(bus.DataValid), 32'd0);
         check("idle_ready", 32'(bus.DataReady), 32'd0);
      end
      check("idle_out_hold", 32'(bus.DataOut), 32'(exp_b[3]));
      bus.TxEnable = 1'b0;
   endtask

   task automatic reset_mid_capture();
      bit stray;
      make_words(3);
      @(negedge DataClk);
      bus.FastTrigger = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge DataClk);
         bus.FastTrigger = 1'b0;
         bus.DataIn      = words[c];
      end
      Reset           = 1'b1;
      bus.FastTrigger = 1'b1;
      bus.TxEnable    = 1'b1;
      @(negedge DataClk);
      check("rst_ready", 32'(bus.DataReady), 32'd0);
      check("rst_valid", 32'(bus.DataValid), 32'd0);
      check("rst_out", 32'(bus.DataOut), 32'd0);
      Reset           = 1'b0;
      bus.FastTrigger = 1'b0;
      stray = 1'b0;
      for (int n = 0; n < 40; n++) begin
         bus.DataIn = $urandom;
         @(negedge DataClk);
         if (bus.DataValid !== 1'b0 || bus.DataReady !== 1'b0) stray = 1'b1;
      end
      check("rst_no_restart", 32'(stray), 32'd0);
      bus.TxEnable = 1'b0;
   endtask

   initial begin
      Reset           = 1'b1;
      bus.FastTrigger = 1'b1;
      bus.TxEnable    = 1'b1;
      bus.DataIn      = $urandom;
      repeat (3) @(negedge DataClk);
      check("reset_ready", 32'(bus.DataReady), 32'd0);
      check("reset_valid", 32'(bus.DataValid), 32'd0);
      check("reset_out", 32'(bus.DataOut), 32'd0);
      Reset           = 1'b0;
      bus.FastTrigger = 1'b0;
      bus.TxEnable    = 1'b0;
      repeat (2) @(negedge DataClk);
      check("post_reset_idle", 32'(bus.DataReady), 32'd0);

      run_capture(0, 0, 1'b0);
      run_capture(1, 3, 1'b0);
      run_capture(2, 2, 1'b1);
      run_capture(0, 0, 1'b0);
      reset_mid_capture();
      run_capture(3, 1, 1'b0);
      for (int r = 0; r < 6; r++) run_capture(3 + (r % 2), r % 4, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
